// File: rtl/arbitro_pkg.sv
// Shared types and constants for the two-master memory arbiter.
//   estado_t : arbiter FSM states
//   id_t     : requester identifier (ID_CPU / ID_HOST)
//   pedido_t : request payload captured at grant time
package arbitro_pkg;

    localparam int unsigned LARGURA  = 16;
    localparam int unsigned ENDERECO = 16;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ACESSO   = 2'd1,
        LEITURA  = 2'd2,
        RESPOSTA = 2'd3
    } estado_t;

    typedef logic id_t;
    localparam id_t ID_CPU  = 1'b0;
    localparam id_t ID_HOST = 1'b1;

    typedef struct packed {
        logic                we;
        logic [ENDERECO-1:0] addr;
        logic [LARGURA-1:0]  wdata;
    } pedido_t;

endpackage

// File: rtl/seletor_vencedor.sv
// Combinational winner select for the memory arbiter.
// Optional build macro: ARB_RR_EN (round-robin tie-break using the
// last-served pointer). Without it the host wins every tie.
// Ports:
//   cpu_req, host_req : pending requests
//   host_lock         : host claims exclusive ownership (CPU ineligible)
//   ultimo            : last-served requester (ARB_RR_EN builds only)
//   valido_c          : some eligible request exists
//   vencedor_c        : selected requester
module seletor_vencedor
    import arbitro_pkg::*;
(
    input  logic cpu_req,
    input  logic host_req,
    input  logic host_lock,
`ifdef ARB_RR_EN
    input  id_t  ultimo,
`endif
    output logic valido_c,
    output id_t  vencedor_c
);

    logic cpu_elegivel;

    assign cpu_elegivel = cpu_req & ~host_lock;

    // Host is the default winner; the CPU takes it when alone or, in the
    // round-robin build, when the host was the last one served.
    always_comb begin
        valido_c   = host_req | cpu_elegivel;
        vencedor_c = ID_HOST;
        if (cpu_elegivel) begin
            if (!host_req) begin
                vencedor_c = ID_CPU;
            end
`ifdef ARB_RR_EN
            else if (ultimo == ID_HOST) begin
                vencedor_c = ID_CPU;
            end
`endif
        end
    end

endmodule

// File: rtl/arbitro_memoria.sv
// Two-requester arbiter (CPU and host/debug loader) for a single-port
// memory with a one-edge read latency. Each access takes four cycles:
// OCIOSO (arbitrate) -> ACESSO -> LEITURA -> RESPOSTA (ack).
// Optional build macro: ARB_RR_EN (round-robin tie-break; otherwise the
// host has fixed priority and the last-served pointer is not built).
// Ports:
//   clk, rst_n                              : clock, async active-low reset
//   cpu_req/we/addr/wdata, cpu_ack/rdata    : CPU request and response
//   host_req/we/addr/wdata, host_lock,
//   host_ack/rdata                          : host request and response
//   mem_addr/mem_data/mem_we, mem_q         : memory interface
//   busy, dono                              : activity and current/last grantee
module arbitro_memoria
    import arbitro_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ENDERECO-1:0] cpu_addr,
    input  logic [LARGURA-1:0]  cpu_wdata,
    output logic                cpu_ack,
    output logic [LARGURA-1:0]  cpu_rdata,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [ENDERECO-1:0] host_addr,
    input  logic [LARGURA-1:0]  host_wdata,
    input  logic                host_lock,
    output logic                host_ack,
    output logic [LARGURA-1:0]  host_rdata,
    output logic [ENDERECO-1:0] mem_addr,
    output logic [LARGURA-1:0]  mem_data,
    output logic                mem_we,
    input  logic [LARGURA-1:0]  mem_q,
    output logic                busy,
    output logic                dono
);

    estado_t estado;
    pedido_t pedido_q;
    logic    valido_c;
    id_t     vencedor_c;
    pedido_t pedido_c;

`ifdef ARB_RR_EN
    id_t     ultimo;
`endif

    seletor_vencedor u_seletor (
        .cpu_req    (cpu_req),
        .host_req   (host_req),
        .host_lock  (host_lock),
`ifdef ARB_RR_EN
        .ultimo     (ultimo),
`endif
        .valido_c   (valido_c),
        .vencedor_c (vencedor_c)
    );

    // Payload of the winning requester, captured only on the grant edge.
    always_comb begin
        pedido_c.we    = cpu_we;
        pedido_c.addr  = cpu_addr;
        pedido_c.wdata = cpu_wdata;
        if (vencedor_c == ID_HOST) begin
            pedido_c.we    = host_we;
            pedido_c.addr  = host_addr;
            pedido_c.wdata = host_wdata;
        end
    end

    // Memory address/data come straight from the captured request so they
    // hold from ACESSO through RESPOSTA (and beyond) without extra muxing.
    assign mem_addr = pedido_q.addr;
    assign mem_data = pedido_q.wdata;

    // Arbiter FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado     <= OCIOSO;
            pedido_q   <= '0;
            mem_we     <= 1'b0;
            cpu_ack    <= 1'b0;
            host_ack   <= 1'b0;
            cpu_rdata  <= '0;
            host_rdata <= '0;
            busy       <= 1'b0;
            dono       <= ID_CPU;
`ifdef ARB_RR_EN
            ultimo     <= ID_HOST;
`endif
        end else begin
            cpu_ack  <= 1'b0;
            host_ack <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (valido_c) begin
                        estado   <= ACESSO;
                        pedido_q <= pedido_c;
                        mem_we   <= pedido_c.we;
                        busy     <= 1'b1;
                        dono     <= vencedor_c;
`ifdef ARB_RR_EN
                        ultimo   <= vencedor_c;
`endif
                    end
                end
                ACESSO: begin
                    estado <= LEITURA;
                    mem_we <= 1'b0;
                end
                LEITURA: begin
                    // mem_q now reflects mem_addr; writes leave rdata alone.
                    estado <= RESPOSTA;
                    if (dono == ID_HOST) begin
                        host_ack <= 1'b1;
                        if (!pedido_q.we) begin
                            host_rdata <= mem_q;
                        end
                    end else begin
                        cpu_ack <= 1'b1;
                        if (!pedido_q.we) begin
                            cpu_rdata <= mem_q;
                        end
                    end
                end
                RESPOSTA: begin
                    estado <= OCIOSO;
                    busy   <= 1'b0;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Self-checking bench for arbitro_memoria: solo transfers from a vector
// table, contention/streaming, host lock, and reset during an access.
// Every ack is matched against a scoreboard of expected grants.
module tb_arbitro_memoria;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [15:0] host_addr = '0, host_wdata = '0;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic [15:0] mem_addr, mem_data, mem_q;
    logic        mem_we, busy, dono;

    arbitro_memoria dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_lock  (host_lock),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_q      (mem_q),
        .busy       (busy),
        .dono       (dono)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory, read data one edge after address.
    logic [15:0] mem [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
    end
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data;
        mem_q <= mem[mem_addr];
    end

    int ciclo = 0;
    always @(posedge clk) ciclo <= ciclo + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_cmp++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nome, atual, esperado, ciclo);
        end
    endtask

    task automatic timeout(input string nome);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for ack (cycle %0d)", nome, ciclo);
    endtask

    // Scoreboard of expected acks in grant order.
    typedef struct {
        logic        id;
        logic [15:0] rdata;
        int          ack_at;
    } sb_t;
    sb_t sb[$];

    // Reference model state.
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] last_rd [2];
    logic        ultimo_m;

    function automatic logic [15:0] rd_ref(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    always @(negedge clk) begin
        if (rst_n && (cpu_ack || host_ack)) begin
            check("ack_exclusive", 32'(cpu_ack & host_ack), 32'd0);
            if (sb.size() == 0) begin
                check("ack_unexpected", 32'({cpu_ack, host_ack}), 32'd0);
            end else begin
                sb_t it;
                it = sb.pop_front();
                check("ack_id", 32'(host_ack), 32'(it.id));
                check("ack_cycle", 32'(ciclo), 32'(it.ack_at));
                check("ack_rdata", 32'(host_ack ? host_rdata : cpu_rdata), 32'(it.rdata));
            end
        end
    end

    task automatic model_reset();
        last_rd[0] = '0;
        last_rd[1] = '0;
        ultimo_m   = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cpu_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic set_master(input logic id, input logic we, input logic [15:0] a, input logic [15:0] d);
        if (id) begin
            host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        end
    endtask

    // One uncontended transfer with per-cycle memory-side checks.
    task automatic run_solo(input logic id, input logic we, input logic [15:0] a,
                            input logic [15:0] d, input logic [15:0] exp_rd);
        logic [15:0] e;
        bit got;
        @(negedge clk);
        set_master(id, we, a, d);
        e = we ? last_rd[id] : exp_rd;
        last_rd[id] = e;
        if (we) ref_mem[a] = d;
        ultimo_m = id;
        sb.push_back('{id: id, rdata: e, ack_at: ciclo + 3});
        @(negedge clk);
        check("acesso_we", 32'(mem_we), 32'(we));
        check("acesso_addr", 32'(mem_addr), 32'(a));
        check("acesso_busy", 32'(busy), 32'd1);
        check("acesso_dono", 32'(dono), 32'(id));
        if (we) check("acesso_data", 32'(mem_data), 32'(d));
        @(negedge clk);
        check("leitura_we", 32'(mem_we), 32'd0);
        check("leitura_addr", 32'(mem_addr), 32'(a));
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            got = id ? host_ack : cpu_ack;
        end
        if (!got) timeout("solo_ack");
        if (id) host_req = 1'b0; else cpu_req = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    // Both masters stream reads (cpu 0x0003, host 0xFFFF); expected grant
    // order comes from the arbitration model. With lock set, the CPU
    // request is left pending on return.
    task automatic contend(input int n_cpu, input int n_host, input logic lock);
        int rc, rh, dc, dh, pushed, seen, t0;
        logic w;
        @(negedge clk);
        t0 = ciclo;
        set_master(1'b0, 1'b0, 16'h0003, 16'h0000);
        set_master(1'b1, 1'b0, 16'hFFFF, 16'h0000);
        cpu_req = (n_cpu > 0);
        host_req = (n_host > 0);
        host_lock = lock;
        rc = n_cpu; rh = n_host; dc = n_cpu; dh = n_host; pushed = 0;
        while ((rc > 0 && !lock) || rh > 0) begin
            if (rc > 0 && !lock && rh > 0) w = RR ? (ultimo_m == 1'b1 ? 1'b0 : 1'b1) : 1'b1;
            else w = (rh > 0);
            if (w) rh--; else rc--;
            last_rd[w] = w ? rd_ref(16'hFFFF) : rd_ref(16'h0003);
            ultimo_m = w;
            sb.push_back('{id: w, rdata: last_rd[w], ack_at: t0 + 3 + 4 * pushed});
            pushed++;
        end
        seen = 0;
        for (int c = 0; c < 4 * pushed + 8 && seen < pushed; c++) begin
            @(negedge clk);
            if (cpu_ack) begin
                seen++; dc--;
                if (dc == 0) cpu_req = 1'b0;
            end
            if (host_ack) begin
                seen++; dh--;
                if (dh == 0) host_req = 1'b0;
            end
        end
        if (seen < pushed) timeout("contend_ack");
    endtask

    typedef struct {
        logic        host;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;
    vec_t tab [8];

    initial begin
        bit got;
        tab[0] = '{host: 1'b0, we: 1'b1, addr: 16'h0003, wdata: 16'h00A5, exp: 16'h0000};
        tab[1] = '{host: 1'b0, we: 1'b0, addr: 16'h0003, wdata: 16'h0000, exp: 16'h00A5};
        tab[2] = '{host: 1'b1, we: 1'b1, addr: 16'hFFFF, wdata: 16'h1234, exp: 16'h0000};
        tab[3] = '{host: 1'b0, we: 1'b0, addr: 16'hFFFF, wdata: 16'h0000, exp: 16'h1234};
        tab[4] = '{host: 1'b1, we: 1'b0, addr: 16'h0003, wdata: 16'h0000, exp: 16'h00A5};
        tab[5] = '{host: 1'b0, we: 1'b1, addr: 16'h0000, wdata: 16'hFFFF, exp: 16'h0000};
        tab[6] = '{host: 1'b1, we: 1'b0, addr: 16'h0000, wdata: 16'h0000, exp: 16'hFFFF};
        tab[7] = '{host: 1'b1, we: 1'b0, addr: 16'hFFFF, wdata: 16'h0000, exp: 16'h1234};
        model_reset();

        // Reset values.
        @(negedge clk);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_host_ack", 32'(host_ack), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_host_rdata", 32'(host_rdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dono", 32'(dono), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Solo transfers from the vector table.
        for (int i = 0; i < 8; i++) begin
            run_solo(tab[i].host, tab[i].we, tab[i].addr, tab[i].wdata, tab[i].exp);
        end

        // Contention from reset, then streaming contention.
        do_reset();
        contend(1, 1, 1'b0);
        contend(3, 3, 1'b0);

        // Host lock with both streaming; CPU served after lock drops.
        contend(1, 3, 1'b1);
        host_lock = 1'b0;
        last_rd[0] = rd_ref(16'h0003);
        ultimo_m = 1'b0;
        sb.push_back('{id: 1'b0, rdata: last_rd[0], ack_at: ciclo + 4});
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            got = cpu_ack;
        end
        if (!got) timeout("unlock_cpu_ack");
        cpu_req = 1'b0;

        // Reset in the middle of a CPU write to 0x0010.
        @(negedge clk);
        set_master(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        @(negedge clk);
        check("abort_we_before", 32'(mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_we", 32'(mem_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cpu_ack", 32'(cpu_ack), 32'd0);
        cpu_req = 1'b0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_solo(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
